// File: rtl/atm_dispense_ctrl.sv
// ATM cash-dispenser sequencer: plans a greedy note breakdown from cassette stock,
// then issues one dispense command per note with ack handshake and jam timeout.
module atm_dispense_ctrl #(
    parameter int AMT_W       = 6,
    parameter int CNT_W       = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AMT_W-1:0] req_units,
    input  logic             refill,
    input  logic [CNT_W-1:0] refill_50k,
    input  logic [CNT_W-1:0] refill_100k,
    input  logic [CNT_W-1:0] refill_200k,
    output logic             disp_50k,
    output logic             disp_100k,
    output logic             disp_200k,
    input  logic             disp_ack,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] cnt_50k,
    output logic [CNT_W-1:0] cnt_100k,
    output logic [CNT_W-1:0] cnt_200k
);

    localparam int PW = ((AMT_W + 2) > CNT_W) ? (AMT_W + 2) : CNT_W;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [PW-1:0]    PW_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    PW_ZERO  = {PW{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0]    TMR_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PLAN, S_DISPENSE, S_WAIT_ACK, S_DONE, S_FAIL
    } state_t;

    typedef enum logic [1:0] {
        D_50K = 2'd0, D_100K = 2'd1, D_200K = 2'd2
    } denom_t;

    function automatic logic [PW-1:0] min_pw(input logic [PW-1:0] a, input logic [PW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Highest denomination still owed; 50k is the fallback when only 50k remain.
    function automatic denom_t pick_denom(input logic [PW-1:0] p200, input logic [PW-1:0] p100);
        if (p200 != PW_ZERO)      return D_200K;
        else if (p100 != PW_ZERO) return D_100K;
        else                      return D_50K;
    endfunction

    state_t           state_r;
    denom_t           cur_r;
    logic [AMT_W-1:0] req_r;
    logic [PW-1:0]    plan_200_r, plan_100_r, plan_50_r;
    logic [TW-1:0]    timer_r;

    logic [PW-1:0] r0_s, r1_s, r2_s, rem_s;
    logic [PW-1:0] n200_s, n100_s, n50_s;
    logic [PW-1:0] nx200_s, nx100_s, nx50_s;
    denom_t        sel_s;
    logic          plan_empty_s;

    assign req_ready = (state_r == S_IDLE) && !refill && !reset;
    assign busy      = (state_r != S_IDLE);

    // Greedy breakdown of the latched amount, and the plan as it stands after one more ack.
    always_comb begin
        r0_s    = PW'(req_r);
        n200_s  = min_pw(r0_s >> 2, PW'(cnt_200k));
        r1_s    = r0_s - (n200_s << 2);
        n100_s  = min_pw(r1_s >> 1, PW'(cnt_100k));
        r2_s    = r1_s - (n100_s << 1);
        n50_s   = min_pw(r2_s, PW'(cnt_50k));
        rem_s   = r2_s - n50_s;
        nx200_s = plan_200_r - ((cur_r == D_200K) ? PW_ONE : PW_ZERO);
        nx100_s = plan_100_r - ((cur_r == D_100K) ? PW_ONE : PW_ZERO);
        nx50_s  = plan_50_r  - ((cur_r == D_50K)  ? PW_ONE : PW_ZERO);
        plan_empty_s = ((nx200_s | nx100_s | nx50_s) == PW_ZERO);
        if (state_r == S_PLAN) begin
            sel_s = pick_denom(n200_s, n100_s);
        end else begin
            sel_s = pick_denom(nx200_s, nx100_s);
        end
    end

    // Controller FSM; every output pulse is registered on entry to its state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= S_IDLE;
            cur_r      <= D_50K;
            req_r      <= {AMT_W{1'b0}};
            plan_200_r <= PW_ZERO;
            plan_100_r <= PW_ZERO;
            plan_50_r  <= PW_ZERO;
            timer_r    <= {TW{1'b0}};
            cnt_50k    <= {CNT_W{1'b0}};
            cnt_100k   <= {CNT_W{1'b0}};
            cnt_200k   <= {CNT_W{1'b0}};
            disp_50k   <= 1'b0;
            disp_100k  <= 1'b0;
            disp_200k  <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            disp_50k  <= 1'b0;
            disp_100k <= 1'b0;
            disp_200k <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (refill) begin
                        cnt_50k  <= refill_50k;
                        cnt_100k <= refill_100k;
                        cnt_200k <= refill_200k;
                    end else if (req_valid) begin
                        req_r    <= req_units;
                        err_code <= 2'b00;
                        if (req_units == {AMT_W{1'b0}}) begin
                            state_r  <= S_FAIL;
                            fail     <= 1'b1;
                            err_code <= 2'b01;
                        end else begin
                            state_r <= S_PLAN;
                        end
                    end
                end
                S_PLAN: begin
                    if (rem_s != PW_ZERO) begin
                        state_r  <= S_FAIL;
                        fail     <= 1'b1;
                        err_code <= 2'b10;
                    end else begin
                        plan_200_r <= n200_s;
                        plan_100_r <= n100_s;
                        plan_50_r  <= n50_s;
                        cur_r      <= sel_s;
                        disp_200k  <= (sel_s == D_200K);
                        disp_100k  <= (sel_s == D_100K);
                        disp_50k   <= (sel_s == D_50K);
                        state_r    <= S_DISPENSE;
                    end
                end
                S_DISPENSE: begin
                    timer_r <= {TW{1'b0}};
                    state_r <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (disp_ack) begin
                        plan_200_r <= nx200_s;
                        plan_100_r <= nx100_s;
                        plan_50_r  <= nx50_s;
                        case (cur_r)
                            D_200K:  cnt_200k <= cnt_200k - CNT_ONE;
                            D_100K:  cnt_100k <= cnt_100k - CNT_ONE;
                            default: cnt_50k  <= cnt_50k - CNT_ONE;
                        endcase
                        if (plan_empty_s) begin
                            state_r <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            cur_r     <= sel_s;
                            disp_200k <= (sel_s == D_200K);
                            disp_100k <= (sel_s == D_100K);
                            disp_50k  <= (sel_s == D_50K);
                            state_r   <= S_DISPENSE;
                        end
                    end else if (timer_r == TMR_LAST) begin
                        state_r  <= S_FAIL;
                        fail     <= 1'b1;
                        err_code <= 2'b11;
                    end else begin
                        timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE:  state_r <= S_IDLE;
                S_FAIL:  state_r <= S_IDLE;
                default: state_r <= S_IDLE;
            endcase
        end
    end

endmodule
